// File: rtl/fp_pkg.sv
// Shared fixed-point helpers: FSM state type and saturating two's-complement add.
package fp_pkg;

  // Widest operand the helpers support; callers sign-extend into this width.
  localparam int unsigned FpMaxW = 64;

  typedef enum logic [0:0] {StAcc, StDone} fp_state_e;

  // Largest value representable in an n-bit signed word, sign-extended to FpMaxW.
  function automatic logic signed [FpMaxW-1:0] sat_max(input int unsigned n);
    logic signed [FpMaxW-1:0] one;
    one = FpMaxW'(1);
    return (one <<< (n - 1)) - one;
  endfunction

  // Smallest value representable in an n-bit signed word, sign-extended to FpMaxW.
  function automatic logic signed [FpMaxW-1:0] sat_min(input int unsigned n);
    return ~sat_max(n);
  endfunction

  // Saturating add of two n-bit values already sign-extended to FpMaxW (n < FpMaxW).
  // Returns {ovf, sum}; sum is clamped to the n-bit rails, sign-extended.
  function automatic logic [FpMaxW:0] fp_sat_add(input logic signed [FpMaxW-1:0] a,
                                                 input logic signed [FpMaxW-1:0] b,
                                                 input int unsigned n);
    logic signed [FpMaxW:0]   s;
    logic signed [FpMaxW:0]   hi;
    logic signed [FpMaxW:0]   lo;
    logic signed [FpMaxW-1:0] mx;
    logic signed [FpMaxW-1:0] mn;
    mx = sat_max(n);
    mn = sat_min(n);
    s  = {a[FpMaxW-1], a} + {b[FpMaxW-1], b};
    hi = {mx[FpMaxW-1], mx};
    lo = {mn[FpMaxW-1], mn};
    if (s > hi) begin
      return {1'b1, mx};
    end else if (s < lo) begin
      return {1'b1, mn};
    end else begin
      return {1'b0, s[FpMaxW-1:0]};
    end
  endfunction

endpackage

// File: rtl/fp_accumulator_if.sv
// Product input stream and sum output stream of the accumulator.
interface fp_accumulator_if #(
  parameter int unsigned n = 32
);
  logic         istream_val;
  logic         istream_rdy;
  logic [n-1:0] istream_msg;
  logic         ostream_val;
  logic         ostream_rdy;
  logic [n-1:0] ostream_msg;
  logic         ostream_ovf;

  // Producer of products / consumer of sums.
  modport master (
    output istream_val, istream_msg, ostream_rdy,
    input  istream_rdy, ostream_val, ostream_msg, ostream_ovf
  );

  // The accumulator itself.
  modport slave (
    input  istream_val, istream_msg, ostream_rdy,
    output istream_rdy, ostream_val, ostream_msg, ostream_ovf
  );
endinterface

// File: rtl/fp_sat_adder.sv
// Combinational n-bit signed saturating adder (n must be below fp_pkg::FpMaxW).
module fp_sat_adder #(
  parameter int unsigned n = 32
) (
  input  logic signed [n-1:0] a,
  input  logic signed [n-1:0] b,
  output logic signed [n-1:0] sum,
  output logic                ovf
);
  import fp_pkg::*;

  logic signed [FpMaxW-1:0] a_ext;
  logic signed [FpMaxW-1:0] b_ext;
  logic        [FpMaxW:0]   res;
  logic                     unused_hi;

  // Widen, add with clamping, then narrow; upper bits only carry the sign extension.
  always_comb begin
    a_ext     = FpMaxW'(a);
    b_ext     = FpMaxW'(b);
    res       = fp_sat_add(a_ext, b_ext, n);
    sum       = res[n-1:0];
    ovf       = res[FpMaxW];
    unused_hi = ^res[FpMaxW-1:n];
  end

endmodule

// File: rtl/fp_accumulator.sv
// Sums groups of L signed fixed-point products with saturation; one sum per group.
module fp_accumulator #(
  parameter int unsigned n = 32,
  parameter int unsigned d = 16,
  parameter int unsigned L = 8
) (
  input logic              clk,
  input logic              reset,
  input logic              clear,
  fp_accumulator_if.slave  s
);
  import fp_pkg::*;

  localparam int unsigned cw = $clog2(L + 1);

  fp_state_e            state_q, state_d;
  logic signed [n-1:0]  acc_q, acc_d;
  logic        [cw-1:0] count_q, count_d;
  logic                 ovf_q, ovf_d;

  logic signed [n-1:0]  base;
  logic signed [n-1:0]  add_sum;
  logic                 add_ovf;
  logic                 in_rdy;
  logic                 in_xfer;

  // Fraction position does not affect addition; kept only for documentation.
  logic [31:0] unused_frac;
  assign unused_frac = d;

  // First element of a group starts from zero rather than the previous sum.
  assign base = (count_q == '0) ? '0 : acc_q;

  fp_sat_adder #(
    .n (n)
  ) u_adder (
    .a   (base),
    .b   (s.istream_msg),
    .sum (add_sum),
    .ovf (add_ovf)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StAcc;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state: clear aborts, sum hand-off, and product accumulation.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    in_xfer = s.istream_val && in_rdy;
    if (clear) begin
      state_d = StAcc;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (state_q == StDone && s.ostream_rdy) begin
        state_d = StAcc;
        acc_d   = '0;
        ovf_d   = 1'b0;
      end
      // A product arriving as the sum leaves becomes element 1 of the next group.
      if (in_xfer) begin
        acc_d = add_sum;
        ovf_d = (count_q == '0) ? add_ovf : (ovf_q | add_ovf);
        if (count_q == cw'(L - 1)) begin
          count_d = '0;
          state_d = StDone;
        end else begin
          count_d = count_q + cw'(1);
          state_d = StAcc;
        end
      end
    end
  end

  // Output decode; ready in DONE follows the consumer for zero-bubble streaming.
  always_comb begin
    in_rdy        = !clear && (state_q == StAcc || s.ostream_rdy);
    s.istream_rdy = in_rdy;
    s.ostream_val = (state_q == StDone);
    s.ostream_msg = acc_q;
    s.ostream_ovf = ovf_q;
  end

endmodule

// File: tb/tb_fp_accumulator.sv
module tb_fp_accumulator;

  logic clk;
  logic reset;
  logic clear;
  logic clear_b;

  int checks;
  int errors;

  fp_accumulator_if #(.n(32)) a_if ();
  fp_accumulator_if #(.n(32)) b_if ();

  fp_accumulator #(
    .n (32),
    .d (16),
    .L (4)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .clear (clear),
    .s     (a_if)
  );

  fp_accumulator #(
    .n (32),
    .d (16),
    .L (1)
  ) u_dut_l1 (
    .clk   (clk),
    .reset (reset),
    .clear (clear_b),
    .s     (b_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one product to the L=4 instance; it must be ready and is taken on the next edge.
  task automatic push_a(input logic [31:0] m);
    a_if.istream_val = 1'b1;
    a_if.istream_msg = m;
    #1;
    check("push_rdy", 32'(a_if.istream_rdy), 32'd1);
    tick();
    a_if.istream_val = 1'b0;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    reset            = 1'b0;
    clear            = 1'b0;
    clear_b          = 1'b0;
    a_if.istream_val = 1'b0;
    a_if.istream_msg = '0;
    a_if.ostream_rdy = 1'b1;
    b_if.istream_val = 1'b0;
    b_if.istream_msg = '0;
    b_if.ostream_rdy = 1'b1;
    #1;
    check("rst_in_rdy", 32'(a_if.istream_rdy), 32'd1);
    check("rst_out_val", 32'(a_if.ostream_val), 32'd0);
    check("rst_out_msg", a_if.ostream_msg, 32'h0);
    check("rst_out_ovf", 32'(a_if.ostream_ovf), 32'd0);
    check("rst_l1_val", 32'(b_if.ostream_val), 32'd0);
    check("rst_l1_rdy", 32'(b_if.istream_rdy), 32'd1);
    tick();
    reset = 1'b1;

    // Basic group: 1.0 + 2.0 - 0.5 + 0.5 = 3.0
    push_a(32'h00010000);
    push_a(32'h00020000);
    push_a(32'hFFFF8000);
    check("basic_val_early", 32'(a_if.ostream_val), 32'd0);
    push_a(32'h00008000);
    check("basic_val", 32'(a_if.ostream_val), 32'd1);
    check("basic_msg", a_if.ostream_msg, 32'h00030000);
    check("basic_ovf", 32'(a_if.ostream_ovf), 32'd0);
    tick();
    check("basic_val_drop", 32'(a_if.ostream_val), 32'd0);

    // Positive saturation, then held under backpressure
    a_if.ostream_rdy = 1'b0;
    push_a(32'h7FFF0000);
    push_a(32'h7FFF0000);
    push_a(32'hFFFF0000);
    push_a(32'h00000000);
    check("psat_val", 32'(a_if.ostream_val), 32'd1);
    check("psat_msg", a_if.ostream_msg, 32'h7FFEFFFF);
    check("psat_ovf", 32'(a_if.ostream_ovf), 32'd1);
    a_if.istream_val = 1'b1;
    a_if.istream_msg = 32'h00010000;
    #1;
    for (int i = 0; i < 5; i++) begin
      check("bp_val", 32'(a_if.ostream_val), 32'd1);
      check("bp_msg", a_if.ostream_msg, 32'h7FFEFFFF);
      check("bp_ovf", 32'(a_if.ostream_ovf), 32'd1);
      check("bp_in_rdy", 32'(a_if.istream_rdy), 32'd0);
      tick();
    end

    // Sum leaves and the waiting product is taken in the same cycle
    a_if.ostream_rdy = 1'b1;
    #1;
    check("b2b_in_rdy", 32'(a_if.istream_rdy), 32'd1);
    tick();
    a_if.istream_val = 1'b0;
    check("b2b_val_drop", 32'(a_if.ostream_val), 32'd0);
    push_a(32'h00010000);
    push_a(32'h00010000);
    push_a(32'h00010000);
    check("b2b_val", 32'(a_if.ostream_val), 32'd1);
    check("b2b_msg", a_if.ostream_msg, 32'h00040000);
    check("b2b_ovf", 32'(a_if.ostream_ovf), 32'd0);
    tick();
    check("b2b_val_drop2", 32'(a_if.ostream_val), 32'd0);

    // clear mid-group discards the partial (saturated) sum
    push_a(32'h7FFF0000);
    push_a(32'h7FFF0000);
    clear = 1'b1;
    #1;
    check("clr_in_rdy", 32'(a_if.istream_rdy), 32'd0);
    tick();
    clear = 1'b0;
    check("clr_val", 32'(a_if.ostream_val), 32'd0);
    push_a(32'h00010000);
    push_a(32'h00010000);
    push_a(32'h00010000);
    check("clr_val_early", 32'(a_if.ostream_val), 32'd0);
    push_a(32'h00010000);
    check("clr_out_val", 32'(a_if.ostream_val), 32'd1);
    check("clr_msg", a_if.ostream_msg, 32'h00040000);
    check("clr_ovf", 32'(a_if.ostream_ovf), 32'd0);
    tick();

    // Negative saturation, then moving back off the rail
    a_if.ostream_rdy = 1'b0;
    push_a(32'h80000000);
    push_a(32'hFFFF0000);
    push_a(32'h00010000);
    push_a(32'h00000000);
    check("nsat_val", 32'(a_if.ostream_val), 32'd1);
    check("nsat_msg", a_if.ostream_msg, 32'h80010000);
    check("nsat_ovf", 32'(a_if.ostream_ovf), 32'd1);

    // Asynchronous reset between edges while holding a sum
    #2;
    reset = 1'b0;
    #1;
    check("arst_val", 32'(a_if.ostream_val), 32'd0);
    check("arst_in_rdy", 32'(a_if.istream_rdy), 32'd1);
    check("arst_msg", a_if.ostream_msg, 32'h0);
    check("arst_ovf", 32'(a_if.ostream_ovf), 32'd0);
    tick();
    reset = 1'b1;
    tick();

    // L=1 streaming: one sum per product, no bubbles
    b_if.istream_val = 1'b1;
    b_if.istream_msg = 32'h80000000;
    #1;
    check("l1_rdy0", 32'(b_if.istream_rdy), 32'd1);
    tick();
    check("l1_val0", 32'(b_if.ostream_val), 32'd1);
    check("l1_msg0", b_if.ostream_msg, 32'h80000000);
    check("l1_ovf0", 32'(b_if.ostream_ovf), 32'd0);
    b_if.istream_msg = 32'h00000001;
    #1;
    check("l1_rdy1", 32'(b_if.istream_rdy), 32'd1);
    tick();
    check("l1_val1", 32'(b_if.ostream_val), 32'd1);
    check("l1_msg1", b_if.ostream_msg, 32'h00000001);
    check("l1_ovf1", 32'(b_if.ostream_ovf), 32'd0);
    b_if.istream_val = 1'b0;
    tick();
    check("l1_val_drop", 32'(b_if.ostream_val), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_accumulator.md
Name: fp_accumulator

Overview:
- Downstream consumer of the fixed-point iterative multiplier's product stream.
- Sums a fixed-length group of L signed fixed-point products with saturating two's-complement addition.
- Emits one n-bit sum per group on a val/rdy output stream, plus a sticky overflow flag.
- Used for dot products and FIR taps built on the multiplier.

Parameters:
- n, 32, bit width of products and of the sum (signed two's complement).
- d, 16, number of fractional bits; informational only, since addition needs no shift.
- L, 8, products per group; legal range 1..2^16-1.
- cw, $clog2(L+1), width of the element counter (localparam).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- clear  input  1  synchronous abort of the current group.
- istream_val  input  1  product valid.
- istream_rdy  output  1  accumulator can accept a product.
- istream_msg  input  n  signed product from the multiplier.
- ostream_val  output  1  group sum valid.
- ostream_rdy  input  1  consumer accepts the sum.
- ostream_msg  output  n  saturated group sum.
- ostream_ovf  output  1  saturation occurred within this group; valid with ostream_val.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ACC, acc=0, count=0, ovf=0.
  - Outputs: istream_rdy=1, ostream_val=0, ostream_msg=0, ostream_ovf=0.
- States:
  - ACC: collecting products.
  - DONE: holding the finished sum.
- Output decode:
  - istream_rdy = (state==ACC) || (state==DONE && ostream_rdy), with clear=0. This lets the next group's first product be accepted in the same cycle the sum leaves, for zero-bubble throughput.
  - ostream_val = (state==DONE). ostream_msg=acc and ostream_ovf=ovf, both held stable while ostream_val=1 && ostream_rdy=0.
- Transfer on istream (val&&rdy):
  - Base value is 0 if count==0, else acc.
  - sum = base + msg, computed at n+1 bits.
  - If the sum exceeds 2^(n-1)-1, acc is clamped to 2^(n-1)-1 and ovf is set. If it is below -2^(n-1), acc is clamped to -2^(n-1) and ovf is set.
  - ovf is cleared at the start of each group (count==0); otherwise it is sticky.
  - count increments.
  - When the accepted product is the L-th: count resets to 0 and the next state is DONE. acc holds the final sum in the cycle ostream_val rises, so latency from the last istream transfer to ostream_val is 1 cycle.
- DONE:
  - On ostream_rdy=1 with no istream transfer: state=ACC, acc=0, ovf=0.
  - On ostream_rdy=1 with a simultaneous istream transfer: state=ACC. That product becomes element 1 of the new group (acc=msg, ovf=0, count=1), or the state returns to DONE immediately if L=1.
  - On ostream_rdy=0: hold all state.
- clear=1 (sampled on the clock edge):
  - Highest priority below reset: state=ACC, acc=0, count=0, ovf=0.
  - istream_rdy=0 in that cycle, so no product is lost mid-transfer.
  - A pending DONE sum is discarded; ostream_val still reads 1 combinationally that cycle and the consumer must ignore it.
- Wrap/boundaries:
  - count never exceeds L-1 in ACC.
  - Saturation holds at the rail: further same-sign products keep the value clamped, and opposite-sign products move it back off the rail normally.
  - An asynchronous reset mid-group drops the partial sum.
- No combinational path from istream_msg to any output.

Decomposition:
- Shared package fp_pkg holds:
  - state enum {ACC, DONE}.
  - Functions sat_max(n) and sat_min(n).
  - A saturating-add function fp_sat_add(a, b) returning {ovf, sum}. The multiplier and the future fp adder will reuse it.
- One sub-module, fp_sat_adder:
  - Combinational n-bit signed saturating adder with outputs sum and ovf.
  - Instantiated once as the datapath.
- Control FSM and counter stay in fp_accumulator.

Test Plan:
- Basic group (n=32, d=16, L=4):
  - Stimulus: products 0x00010000, 0x00020000, 0xFFFF8000, 0x00008000 (1.0, 2.0, -0.5, 0.5), ostream_rdy=1.
  - Response: ostream_msg=0x00030000, ostream_ovf=0, ostream_val high exactly 1 cycle after the 4th transfer.
- Positive saturation (L=4):
  - Stimulus: 0x7FFF0000, 0x7FFF0000, 0xFFFF0000, 0x00000000.
  - Response: ostream_msg=0x7FFEFFFF, i.e. clamped to 0x7FFFFFFF then reduced by 1.0; ostream_ovf=1.
- Backpressure and back-to-back:
  - Stimulus: hold ostream_rdy=0 for 5 cycles after DONE.
  - Response: msg and ovf stable, istream_rdy=0.
  - Stimulus: raise ostream_rdy with istream_val=1 and msg=0x00010000.
  - Response: the product is accepted the same cycle, and the next group's sum includes it (group 2 all 1.0 gives 0x00040000).
- clear mid-group:
  - Stimulus: accept 2 products, assert clear for 1 cycle, then send 4 × 0x00010000.
  - Response: ostream_msg=0x00040000, and no stale contribution.
- Async reset:
  - Stimulus: drive reset=0 between clock edges while in DONE.
  - Response: ostream_val drops immediately without waiting for an edge, and all outputs show their reset values.
- L=1 (parameter override), streaming:
  - Stimulus: 0x80000000, 0x00000001 with ostream_rdy=1.
  - Response: outputs 0x80000000 then 0x00000001, one sum per input, no bubbles.
